// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB first, repeat_cnt times, with gap_len idle cycles between.
// Define SEQGEN_PRBS_FILL_EN to drive gap cycles from a 7-bit LFSR (x^7+x^6+1) instead of zeros.
module seq_pattern_gen #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             t,
  output logic             t_valid,
  output logic             marker,
  output logic             busy,
  output logic             done
);
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] reps, reps_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic             t_n, tv_n, mk_n, busy_n, done_n;
  logic             fill;
`ifdef SEQGEN_PRBS_FILL_EN
  logic [6:0]       lfsr, lfsr_n;
`endif

  // Outputs are computed for the next state and registered, so the
  // state register always matches what is on the pins this cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    reps_n  = reps;
    gap_n   = gap_q;
    gcnt_n  = gcnt;
    t_n     = 1'b0;
    tv_n    = 1'b0;
    mk_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
`ifdef SEQGEN_PRBS_FILL_EN
    fill    = lfsr[6];
    lfsr_n  = lfsr;
`else
    fill    = 1'b0;
`endif
    case (state)
      // FIN is the done cycle; a held start is already accepted there.
      IDLE, FIN: begin
        state_n = IDLE;
        if (start) begin
          reps_n = repeat_cnt;
          gap_n  = gap_len;
          if (repeat_cnt == '0) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            state_n = SEND;
            idx_n   = IDX_TOP;
            t_n     = PATTERN[PAT_W-1];
            tv_n    = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_n = IDLE;
        end else if (idx != '0) begin
          idx_n  = idx - IDX_W'(1);
          t_n    = PATTERN[idx_n];
          tv_n   = 1'b1;
          mk_n   = (idx_n == '0);
          busy_n = 1'b1;
        end else begin
          reps_n = reps - CNT_W'(1);
          if (reps == CNT_W'(1)) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else if (gap_q == '0) begin
            idx_n  = IDX_TOP;
            t_n    = PATTERN[PAT_W-1];
            tv_n   = 1'b1;
            busy_n = 1'b1;
          end else begin
            state_n = GAP;
            gcnt_n  = gap_q;
            t_n     = fill;
            busy_n  = 1'b1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (gcnt == GAP_W'(1)) begin
          state_n = SEND;
          idx_n   = IDX_TOP;
          t_n     = PATTERN[PAT_W-1];
          tv_n    = 1'b1;
          busy_n  = 1'b1;
        end else begin
          gcnt_n = gcnt - GAP_W'(1);
          t_n    = fill;
          busy_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SEQGEN_PRBS_FILL_EN
    // Advance once per gap cycle, after its MSB has been put on t.
    if (state_n == GAP) lfsr_n = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      reps    <= '0;
      gap_q   <= '0;
      gcnt    <= '0;
      t       <= 1'b0;
      t_valid <= 1'b0;
      marker  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQGEN_PRBS_FILL_EN
      lfsr    <= 7'h7F;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      reps    <= reps_n;
      gap_q   <= gap_n;
      gcnt    <= gcnt_n;
      t       <= t_n;
      t_valid <= tv_n;
      marker  <= mk_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SEQGEN_PRBS_FILL_EN
      lfsr    <= lfsr_n;
`endif
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: vector table for gap/zero/single runs, hand sequences for
// back-to-back with held start, abort and asynchronous reset. Expected word is {t,t_valid,marker,busy,done}.
module tb_seq_pattern_gen;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] repeat_cnt = '0;
  logic [3:0] gap_len = '0;
  logic       t, t_valid, marker, busy, done;
  int         checks = 0, failures = 0;

`ifdef SEQGEN_PRBS_FILL_EN
  localparam logic GF = 1'b1;  // first three MSBs from seed 7F are 1,1,1
`else
  localparam logic GF = 1'b0;
`endif

  seq_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len),
    .t(t), .t_valid(t_valid), .marker(marker), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       a;
    logic [7:0] rc;
    logic [3:0] gl;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic a, input logic [7:0] rc,
                     input logic [3:0] gl, input logic [4:0] exp);
    vec_t v;
    v.s = s; v.a = a; v.rc = rc; v.gl = gl; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [4:0] e);
    logic [4:0] got;
    got = {t, t_valid, marker, busy, done};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (t,t_valid,marker,busy,done)", nm, got, e);
    end
  endtask

  task automatic cyc(input logic s, input logic a, input logic [7:0] rc, input logic [3:0] gl);
    @(negedge clk);
    start = s; abort = a; repeat_cnt = rc; gap_len = gl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] stream;
    stream = 12'b101110111011;

    // gap run: rc=2, gap=3; a start with new values mid-gap must be ignored
    add(1, 0, 2, 3, 5'b11010);
    add(0, 0, 2, 3, 5'b01010);
    add(0, 0, 2, 3, 5'b11010);
    add(0, 0, 2, 3, 5'b11110);
    add(0, 0, 2, 3, {GF, 4'b0010});
    add(1, 0, 0, 0, {GF, 4'b0010});
    add(0, 0, 2, 3, {GF, 4'b0010});
    add(0, 0, 2, 3, 5'b11010);
    add(0, 0, 2, 3, 5'b01010);
    add(0, 0, 2, 3, 5'b11010);
    add(0, 0, 2, 3, 5'b11110);
    add(0, 0, 2, 3, 5'b00001);
    add(0, 1, 2, 3, 5'b00000);  // abort in IDLE: no effect
    // repeat_cnt=0: done right away, no bits
    add(1, 0, 0, 5, 5'b00001);
    add(0, 0, 0, 0, 5'b00000);
    // single run, start together with abort: start wins
    add(1, 1, 1, 0, 5'b11010);
    add(0, 0, 1, 0, 5'b01010);
    add(0, 0, 1, 0, 5'b11010);
    add(0, 0, 1, 0, 5'b11110);
    add(0, 0, 1, 0, 5'b00001);
    add(0, 0, 1, 0, 5'b00000);

    #1;
    check("reset_state", 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    check("idle_after_reset", 5'b00000);

    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].a, tbl[i].rc, tbl[i].gl);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // back-to-back rc=3 gap=0 with start held for the whole run
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 3, 0);
      check($sformatf("b2b_bit%0d", i), {stream[11-i], 1'b1, (i % 4 == 3), 1'b1, 1'b0});
    end
    cyc(1, 0, 3, 0);
    check("b2b_done", 5'b00001);
    cyc(1, 0, 3, 0);
    check("held_start_reaccept", 5'b11010);
    cyc(0, 1, 3, 0);
    check("abort_rep1", 5'b00000);
    cyc(0, 0, 3, 0);
    check("abort_no_done", 5'b00000);

    // abort during 2nd bit of rep 2 of 3
    cyc(1, 0, 3, 0); check("ab_r1b0", 5'b11010);
    cyc(0, 0, 3, 0); check("ab_r1b1", 5'b01010);
    cyc(0, 0, 3, 0); check("ab_r1b2", 5'b11010);
    cyc(0, 0, 3, 0); check("ab_r1b3", 5'b11110);
    cyc(0, 0, 3, 0); check("ab_r2b0", 5'b11010);
    cyc(0, 0, 3, 0); check("ab_r2b1", 5'b01010);
    cyc(0, 1, 3, 0); check("ab_idle", 5'b00000);
    cyc(0, 0, 3, 0); check("ab_no_done", 5'b00000);
    cyc(1, 0, 1, 0); check("ab_new_b0", 5'b11010);
    cyc(0, 0, 1, 0); check("ab_new_b1", 5'b01010);
    cyc(0, 0, 1, 0); check("ab_new_b2", 5'b11010);
    cyc(0, 0, 1, 0); check("ab_new_b3", 5'b11110);
    cyc(0, 0, 1, 0); check("ab_new_done", 5'b00001);

    // asynchronous reset mid-SEND
    cyc(1, 0, 3, 0); check("rst_r1b0", 5'b11010);
    cyc(0, 0, 3, 0); check("rst_r1b1", 5'b01010);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 3, 0);
      check($sformatf("no_resume%0d", i), 5'b00000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
